collector_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one Collector (sink PE) among NUM_REQ upstream

---
 rtl/collector_rr_arbiter_if.sv | 27 ++
 rtl/collector_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_collector_rr_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/collector_rr_arbiter_if.sv
// Req/Gnt/Full bundle between NUM_REQ requesters, the round-robin arbiter and one Collector.
// The slave modport is the arbiter's view; master is the requester/Collector side.
interface collector_rr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int dataWidth = 32
);
    logic [NUM_REQ*dataWidth-1:0] PacketIn;
    logic [NUM_REQ-1:0]           ReqUpStr;
    logic [NUM_REQ-1:0]           GntUpStr;
    logic [NUM_REQ-1:0]           UpStrFull;
    logic [dataWidth-1:0]         PacketOut;
    logic                         ReqDnStr;
    logic                         GntDnStr;
    logic                         DnStrFull;

    // Handshake: a side raises Req with its packet stable and holds both until it sees
    // a one-cycle Gnt; the edge that samples Gnt is the edge that consumes the packet.
    modport slave (
        input  PacketIn, ReqUpStr, GntDnStr, DnStrFull,
        output GntUpStr, UpStrFull, PacketOut, ReqDnStr
    );

    modport master (
        output PacketIn, ReqUpStr, GntDnStr, DnStrFull,
        input  GntUpStr, UpStrFull, PacketOut, ReqDnStr
    );
endinterface

// File: rtl/collector_rr_arbiter.sv
// Round-robin arbiter sharing one Collector among NUM_REQ requesters, one packet at a time.
// Optional grant watchdog and sticky ArbTimeout flag: define COLLECTOR_ARB_TIMEOUT_EN.
module collector_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2,
    parameter int dataWidth = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    collector_rr_arbiter_if.slave bus,
`ifdef COLLECTOR_ARB_TIMEOUT_EN
    output logic             ArbTimeout,
`endif
    output logic [1:0]       dbgState,
    output logic [IDX_W-1:0] dbgLast
);

    if (((1 << IDX_W) != NUM_REQ) || (NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT < 1)) begin : gParamCheck
        $error("collector_rr_arbiter: bad NUM_REQ/IDX_W/TIMEOUT combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } arbState_t;

    arbState_t            state, stateNext;
    logic [IDX_W-1:0]     last, lastNext;
    logic [IDX_W-1:0]     winner, winnerNext;
    logic [dataWidth-1:0] packetReg, packetNext;
    logic                 reqDn, reqDnNext;
    logic [NUM_REQ-1:0]   gntUp, gntUpNext;
    logic [NUM_REQ-1:0]   fullReg, fullNext;
    logic                 found;
    logic [IDX_W-1:0]     pick, cand;

`ifdef COLLECTOR_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             timeoutReg, timeoutNext;
`endif

    // Search starts just after the last winner; index arithmetic wraps because NUM_REQ is 2**IDX_W.
    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!found && bus.ReqUpStr[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        lastNext   = last;
        winnerNext = winner;
        packetNext = packetReg;
        reqDnNext  = reqDn;
        gntUpNext  = '0;
        fullNext   = '0;
`ifdef COLLECTOR_ARB_TIMEOUT_EN
        cntNext     = cnt;
        timeoutNext = timeoutReg;
`endif
        case (state)
            IDLE: begin
                if (!bus.DnStrFull && found) begin
                    stateNext  = REQ;
                    winnerNext = pick;
                    packetNext = bus.PacketIn[int'(pick)*dataWidth +: dataWidth];
                    reqDnNext  = 1'b1;
`ifdef COLLECTOR_ARB_TIMEOUT_EN
                    cntNext    = '0;
`endif
                end
            end
            REQ: begin
                if (bus.GntDnStr) begin
                    reqDnNext         = 1'b0;
                    gntUpNext[winner] = 1'b1;
                    lastNext          = winner;
                    stateNext         = ACK;
                end
`ifdef COLLECTOR_ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    reqDnNext   = 1'b0;
                    lastNext    = winner;
                    timeoutNext = 1'b1;
                    stateNext   = IDLE;
                end else begin
                    cntNext = cnt + 1'b1;
                end
`endif
            end
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // A requester that lost arbitration always sees a non-IDLE next state, so the
        // busy term alone covers it; only the requester being served reads as not full.
        for (int i = 0; i < NUM_REQ; i++) begin
            fullNext[i] = bus.DnStrFull | ((stateNext != IDLE) && (IDX_W'(i) != winnerNext));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            winner    <= '0;
            packetReg <= '0;
            reqDn     <= 1'b0;
            gntUp     <= '0;
            fullReg   <= '0;
`ifdef COLLECTOR_ARB_TIMEOUT_EN
            cnt        <= '0;
            timeoutReg <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            last      <= lastNext;
            winner    <= winnerNext;
            packetReg <= packetNext;
            reqDn     <= reqDnNext;
            gntUp     <= gntUpNext;
            fullReg   <= fullNext;
`ifdef COLLECTOR_ARB_TIMEOUT_EN
            cnt        <= cntNext;
            timeoutReg <= timeoutNext;
`endif
        end
    end

    assign bus.GntUpStr  = gntUp;
    assign bus.UpStrFull = fullReg;
    assign bus.PacketOut = packetReg;
    assign bus.ReqDnStr  = reqDn;
    assign dbgState      = state;
    assign dbgLast       = last;
`ifdef COLLECTOR_ARB_TIMEOUT_EN
    assign ArbTimeout    = timeoutReg;
`endif

endmodule

// File: tb/tb_collector_rr_arbiter.sv
// Directed bench for collector_rr_arbiter: single request, fairness, back-pressure, wrap,
// mid-transfer reset and (with COLLECTOR_ARB_TIMEOUT_EN) the grant watchdog.
module tb_collector_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ackEn;
    logic       collGnt;
    logic [1:0] dbgState;
    logic [1:0] dbgLast;
    int         nAsserts = 0;
    int         nFail    = 0;
    logic [3:0] g;
    int         n;
`ifdef COLLECTOR_ARB_TIMEOUT_EN
    logic       arbTimeout;
`endif

    collector_rr_arbiter_if #(.NUM_REQ(4), .dataWidth(32)) bus ();

    collector_rr_arbiter #(
        .NUM_REQ(4), .IDX_W(2), .dataWidth(32), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
`ifdef COLLECTOR_ARB_TIMEOUT_EN
        .ArbTimeout(arbTimeout),
`endif
        .dbgState(dbgState),
        .dbgLast(dbgLast)
    );

    always #5 clk = ~clk;

    // Collector model: registered grant, one cycle after it sees ReqDnStr, for one cycle.
    always @(posedge clk) begin
        if (reset) collGnt <= 1'b0;
        else       collGnt <= ackEn && bus.ReqDnStr && !collGnt;
    end
    assign bus.GntDnStr = collGnt;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitGrant(output logic [3:0] gnt, output int cycles);
        gnt    = '0;
        cycles = 0;
        while (gnt == 4'b0 && cycles < 20) begin
            @(negedge clk);
            cycles++;
            gnt = bus.GntUpStr;
        end
    endtask

    initial begin
        reset         = 1'b1;
        ackEn         = 1'b0;
        bus.PacketIn  = '0;
        bus.ReqUpStr  = '0;
        bus.DnStrFull = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt",   bus.GntUpStr,  4'b0000);
        check("rst_full",  bus.UpStrFull, 4'b0000);
        check("rst_reqdn", bus.ReqDnStr,  1'b0);
        check("rst_pkt",   bus.PacketOut, 32'h0);
        check("rst_state", dbgState,      2'd0);
        check("rst_last",  dbgLast,       2'd3);
        reset = 1'b0;

        // Single request from requester 2
        bus.PacketIn[2*32 +: 32] = 32'hA5A5_0123;
        bus.ReqUpStr = 4'b0100;
        ackEn        = 1'b1;
        @(negedge clk);
        check("t1_reqdn",     bus.ReqDnStr,  1'b1);
        check("t1_pkt",       bus.PacketOut, 32'hA5A5_0123);
        check("t1_full",      bus.UpStrFull, 4'b1011);
        check("t1_gnt_early", bus.GntUpStr,  4'b0000);
        @(negedge clk);
        check("t1_gnt_wait",  bus.GntUpStr,  4'b0000);
        check("t1_reqdn_hold", bus.ReqDnStr, 1'b1);
        @(negedge clk);
        check("t1_gnt",       bus.GntUpStr,  4'b0100);
        check("t1_reqdn_drop", bus.ReqDnStr, 1'b0);
        check("t1_pkt_hold",  bus.PacketOut, 32'hA5A5_0123);
        bus.ReqUpStr = 4'b0000;
        @(negedge clk);
        check("t1_gnt_pulse", bus.GntUpStr,  4'b0000);
        check("t1_full_idle", bus.UpStrFull, 4'b0000);
        check("t1_last",      dbgLast,       2'd2);

        // All four requesting continuously from reset
        reset        = 1'b1;
        bus.ReqUpStr = 4'b1111;
        for (int i = 0; i < 4; i++) bus.PacketIn[i*32 +: 32] = 32'hC0DE_0000 + i;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            waitGrant(g, n);
            check($sformatf("t2_gnt%0d", k),   g,             32'(1) << (k % 4));
            check($sformatf("t2_pkt%0d", k),   bus.PacketOut, 32'hC0DE_0000 + (k % 4));
            check($sformatf("t2_cyc%0d", k),   n,             (k == 0) ? 3 : 4);
        end
        bus.ReqUpStr = 4'b0000;
        @(negedge clk);

        // Collector full: nothing forwarded, everyone sees full
        bus.DnStrFull = 1'b1;
        bus.ReqUpStr  = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("t3_reqdn%0d", k), bus.ReqDnStr, 1'b0);
        end
        check("t3_full", bus.UpStrFull, 4'b1111);
        bus.DnStrFull = 1'b0;
        waitGrant(g, n);
        check("t3_first_gnt", g,             4'b0001);
        check("t3_first_pkt", bus.PacketOut, 32'hC0DE_0000);
        check("t3_first_cyc", n,             3);
        bus.ReqUpStr = 4'b0010;
        waitGrant(g, n);
        check("t3_second_gnt", g,            4'b0010);
        check("t3_second_cyc", n,            4);
        bus.ReqUpStr = 4'b0000;

        // Wrap: make requester 3 the last winner, then 0 and 3 compete
        waitGrant(g, n);
        check("t4_idle_nognt", g, 4'b0000);
        bus.ReqUpStr = 4'b1000;
        waitGrant(g, n);
        check("t4_pre_gnt", g, 4'b1000);
        bus.ReqUpStr = 4'b0000;
        @(negedge clk);
        check("t4_last3", dbgLast, 2'd3);
        bus.ReqUpStr = 4'b1001;
        waitGrant(g, n);
        check("t4_wrap_gnt", g, 4'b0001);
        bus.ReqUpStr = 4'b1000;
        waitGrant(g, n);
        check("t4_next_gnt", g,             4'b1000);
        check("t4_next_pkt", bus.PacketOut, 32'hC0DE_0003);
        bus.ReqUpStr = 4'b0000;
        @(negedge clk);

        // Reset while waiting for the Collector
        ackEn = 1'b0;
        bus.PacketIn[1*32 +: 32] = 32'h5555_AAAA;
        bus.ReqUpStr = 4'b0010;
        @(negedge clk);
        check("t5_reqdn", bus.ReqDnStr, 1'b1);
        check("t5_state", dbgState,     2'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_reqdn", bus.ReqDnStr,  1'b0);
        check("t5_rst_gnt",   bus.GntUpStr,  4'b0000);
        check("t5_rst_full",  bus.UpStrFull, 4'b0000);
        check("t5_rst_pkt",   bus.PacketOut, 32'h0);
        check("t5_rst_state", dbgState,      2'd0);
        check("t5_rst_last",  dbgLast,       2'd3);
        reset = 1'b0;
        ackEn = 1'b1;
        waitGrant(g, n);
        check("t5_regnt",     g,             4'b0010);
        check("t5_regnt_pkt", bus.PacketOut, 32'h5555_AAAA);
        check("t5_regnt_cyc", n,             3);
        bus.ReqUpStr = 4'b0000;
        @(negedge clk);

`ifdef COLLECTOR_ARB_TIMEOUT_EN
        // Collector never grants: watchdog releases after 8 REQ cycles
        ackEn = 1'b0;
        bus.ReqUpStr = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t6_reqdn%0d", k), bus.ReqDnStr, 1'b1);
            check($sformatf("t6_gnt%0d", k),   bus.GntUpStr, 4'b0000);
            check($sformatf("t6_to%0d", k),    arbTimeout,   1'b0);
        end
        @(negedge clk);
        check("t6_reqdn_drop", bus.ReqDnStr, 1'b0);
        check("t6_to_set",     arbTimeout,   1'b1);
        check("t6_no_gnt",     bus.GntUpStr, 4'b0000);
        check("t6_idle",       dbgState,     2'd0);
        @(negedge clk);
        check("t6_rearb",      bus.ReqDnStr, 1'b1);
        check("t6_sticky",     arbTimeout,   1'b1);
        bus.ReqUpStr = 4'b0000;
        reset = 1'b1;
        @(negedge clk);
        check("t6_to_clear",   arbTimeout,   1'b0);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
